inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Parametrised, byte-banked instruction memory with a one-cycle fetch port and a byte-stream boot-loader port. The fetch port serves the core's instruction fetch stage. The loader fills memory from a serial or debug byte source before or between runs. Storage is split into `DATA_WIDTH/8` independent byte lanes, so a partial final word leaves its untouched lanes intact.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: fetch byte-address width.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8; `BYTES = DATA_WIDTH/8`.
- `DEPTH`, 4096: number of words; power of two.
- `LOAD_BASE`, 0: byte address of the first loaded byte; must be `BYTES`-aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_req_i`  in  1  fetch request.
- `fetch_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `fetch_gnt_o`  out  1  request accepted this cycle; combinational.
- `fetch_rvalid_o`  out  1  response valid.
- `fetch_rdata_o`  out  DATA_WIDTH  instruction word.
- `fetch_err_o`  out  1  response is an error (misaligned or out of range).
- `load_start_i`  in  1  start a load; honoured only in IDLE.
- `load_len_i`  in  ADDR_WIDTH  number of bytes to load; sampled with `load_start_i`.
- `load_valid_i`  in  1  `load_byte_i` is valid.
- `load_byte_i`  in  8  stream byte.
- `load_ready_o`  out  1  loader accepts a byte this cycle.
- `load_busy_o`  out  1  loader is in LOAD or DONE.
- `load_done_o`  out  1  one-cycle completion pulse.
- `load_ovf_o`  out  1  at least one byte of the load was discarded as out of range; valid while `load_done_o` is high, 0 otherwise.

## Operation
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on `load_start_i` with `load_len_i != 0`. Byte counter cleared; `len` latched.
  - IDLE -> DONE on `load_start_i` with `load_len_i == 0`.
  - LOAD -> DONE when the accepted byte is byte number `len-1`.
  - DONE -> IDLE unconditionally after one cycle.
- `load_ready_o = (state == LOAD)`. A byte is accepted when `load_valid_i & load_ready_o`.
- Byte placement, for byte `k` (0-based), with `b = LOAD_BASE + k`:
  - lane `= b mod BYTES` (little-endian: lane 0 = bits [7:0]);
  - word `= b / BYTES`.
- If word `>= DEPTH`, the byte is not written and the sticky overflow flag is set. The flag is cleared on entry to LOAD and presented on `load_ovf_o` during DONE.
- The byte counter is ADDR_WIDTH bits wide. The address sum wraps modulo `2^ADDR_WIDTH`, and a wrapped address is checked against `DEPTH` in the same way.
- Lanes not written by a load keep their previous contents. Memory contents are not reset.
- `load_start_i` outside IDLE is ignored.
- `fetch_gnt_o = fetch_req_i & (state == IDLE) & ~load_start_i`. The loader wins a same-cycle collision.
- An accepted fetch with `addr[log2(BYTES)-1:0] != 0` or `addr/BYTES >= DEPTH` returns `fetch_err_o = 1`, `fetch_rdata_o = 0`. Otherwise it returns `{lane[BYTES-1]..lane[0]}` at word `addr/BYTES`, with `err = 0`.
- A non-granted request produces no response. The requester holds `fetch_req_i`/`fetch_addr_i` until granted.

## Timing
- Reset values:
  - state IDLE;
  - `fetch_rvalid_o`, `fetch_err_o`, `load_ready_o`, `load_busy_o`, `load_done_o`, `load_ovf_o` all 0;
  - `fetch_rdata_o` 0;
  - counter 0, overflow flag 0.
- Fetch latency:
  - a grant at edge N gives `fetch_rvalid_o` = 1 in cycle N+1, with data and error;
  - back-to-back grants give one response per cycle;
  - without a grant, `fetch_rvalid_o` = 0 and `fetch_rdata_o` holds its last value.
- Load write latency: an accepted byte is written at the same edge and is readable by a fetch granted on the next cycle.
- `load_done_o` is high for exactly the one cycle after the edge that accepted the last byte, or the edge after a zero-length start. `load_busy_o` is high in LOAD and DONE.
- Reset mid-load:
  - FSM returns to IDLE immediately; counter and overflow flag are cleared;
  - bytes already written remain; no `load_done_o` pulse.
- Reset with a fetch outstanding: the response is dropped; `fetch_rvalid_o` = 0 while `rst_n` = 0.

## Test plan
- Load 8 bytes `01..08`, `LOAD_BASE=0`, 32-bit word.
  - Fetch address 0 -> `0x04030201`; fetch address 4 -> `0x08070605`; `err` 0, `ovf` 0.
  - `load_done_o` pulses once, one cycle after byte 8 is accepted.
- Preload word 1 with `0xDEADBEEF`, then load 6 bytes `11..16`.
  - Fetch address 4 -> `0xDEAD1615`: lanes 2-3 are untouched.
- Fetch address 2 -> `rvalid` with `err=1`, `rdata=0`.
  - Fetch address `DEPTH*4` -> `err=1`.
  - Back-to-back fetches of 0, 4, 8 -> three consecutive `rvalid` cycles in order.
- `load_start_i` and `fetch_req_i` asserted in the same cycle -> `fetch_gnt_o=0`.
  - Fetch is granted in the first cycle after DONE.
  - `load_start_i` re-asserted during LOAD is ignored.
- Load with `LOAD_BASE=(DEPTH-1)*4` and length 8.
  - Last word is written; `load_ovf_o=1` in the DONE cycle.
  - Zero-length start -> `load_done_o` on the next cycle, `ovf=0`.
- Deassert `rst_n` after 3 of 8 bytes.
  - All outputs go to 0 immediately and `load_done_o` never pulses.
  - The 3 written bytes read back correctly after reset.

Source files
------------

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_loader
// Description : Byte-banked instruction memory with a one-cycle fetch port
//               and a byte-stream boot-loader port. Each byte lane is an
//               independent array, so partial words keep untouched lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int LOAD_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction fetch port
    input  logic                  fetch_req_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0] fetch_rdata_o,
    output logic                  fetch_err_o,
    // boot-loader byte stream port
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH-1:0] load_len_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    output logic                  load_ready_o,
    output logic                  load_busy_o,
    output logic                  load_done_o,
    output logic                  load_ovf_o
);

    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LANE_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_BASE    = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] c_BYTES_A = ADDR_WIDTH'(c_BYTES);
    // One extra bit so a DEPTH equal to 2^ADDR_WIDTH words still compares correctly
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_len;
    logic                  r_ovf;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_ld_addr;
    logic [ADDR_WIDTH-1:0] w_ld_word;
    logic [c_LANE_W-1:0]   w_ld_lane;
    logic                  w_ld_inrange;
    logic [c_IDX_W-1:0]    w_ld_idx;

    logic                  w_gnt;
    logic [ADDR_WIDTH-1:0] w_f_word;
    logic                  w_f_mis;
    logic                  w_f_oor;
    logic                  w_f_err;
    logic [c_IDX_W-1:0]    w_f_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // ------------------------------------------------------------------
    // Loader handshake and byte placement
    // ------------------------------------------------------------------
    assign w_start  = load_start_i & (r_state == S_IDLE);
    assign w_accept = load_valid_i & (r_state == S_LOAD);
    assign w_last   = w_accept & (r_cnt == (r_len - 1'b1));

    // Address sum intentionally wraps modulo 2^ADDR_WIDTH; a wrapped
    // address is range-checked exactly like any other.
    assign w_ld_addr    = c_BASE + r_cnt;
    assign w_ld_word    = w_ld_addr / c_BYTES_A;
    assign w_ld_lane    = c_LANE_W'(w_ld_addr % c_BYTES_A);
    assign w_ld_inrange = ({1'b0, w_ld_word} < c_DEPTH_W);
    assign w_ld_idx     = w_ld_word[c_IDX_W-1:0];

    // ------------------------------------------------------------------
    // Fetch arbitration and decode; the loader wins a same-cycle collision
    // ------------------------------------------------------------------
    assign w_gnt    = fetch_req_i & (r_state == S_IDLE) & ~load_start_i;
    assign w_f_word = fetch_addr_i / c_BYTES_A;
    assign w_f_mis  = ((fetch_addr_i % c_BYTES_A) != '0);
    assign w_f_oor  = ~({1'b0, w_f_word} < c_DEPTH_W);
    assign w_f_err  = w_f_mis | w_f_oor;
    assign w_f_idx  = w_f_word[c_IDX_W-1:0];

    // ------------------------------------------------------------------
    // Byte-lane storage: one array per lane, contents never reset
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            // Write the accepted byte into this lane when it targets it and is in range
            always_ff @(posedge clk) begin
                if (w_accept && w_ld_inrange && (w_ld_lane == c_LANE_W'(gi))) begin
                    r_mem[w_ld_idx] <= load_byte_i;
                end
            end

            assign w_rd_word[8*gi +: 8] = r_mem[w_f_idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------

    // State register; reset drops any load in progress without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start outside IDLE is ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = (load_len_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte counter, latched length and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_len <= load_len_i;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_ld_inrange) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Fetch response register; data holds when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_err   <= w_f_err;
                r_rdata <= w_f_err ? '0 : w_rd_word;
            end
        end
    end

    assign fetch_gnt_o    = w_gnt;
    assign fetch_rvalid_o = r_rvalid;
    assign fetch_rdata_o  = r_rdata;
    assign fetch_err_o    = r_err;

    assign load_ready_o   = (r_state == S_LOAD);
    assign load_busy_o    = (r_state == S_LOAD) | (r_state == S_DONE);
    assign load_done_o    = (r_state == S_DONE);
    assign load_ovf_o     = (r_state == S_DONE) & r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_loader
// Description : Directed self-checking bench for inst_rom_loader. Two
//               instances share all inputs: A loads from byte 0, B loads
//               from the last word so its loads run off the end of memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_loader;

    localparam int c_AW    = 32;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic            fetch_req;
    logic [c_AW-1:0] fetch_addr;
    logic            load_start;
    logic [c_AW-1:0] load_len;
    logic            load_valid;
    logic [7:0]      load_byte;

    logic            a_gnt, a_rvalid, a_err, a_ready, a_busy, a_done, a_ovf;
    logic [c_DW-1:0] a_rdata;
    logic            b_gnt, b_rvalid, b_err, b_ready, b_busy, b_done, b_ovf;
    logic [c_DW-1:0] b_rdata;

    int              checks;
    int              failures;
    int              done_cnt;
    logic [7:0]      stim [0:15];

    inst_rom_loader #(
        .ADDR_WIDTH (c_AW), .DATA_WIDTH (c_DW), .DEPTH (c_DEPTH), .LOAD_BASE (0)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .fetch_req_i (fetch_req), .fetch_addr_i (fetch_addr),
        .fetch_gnt_o (a_gnt), .fetch_rvalid_o (a_rvalid),
        .fetch_rdata_o (a_rdata), .fetch_err_o (a_err),
        .load_start_i (load_start), .load_len_i (load_len),
        .load_valid_i (load_valid), .load_byte_i (load_byte),
        .load_ready_o (a_ready), .load_busy_o (a_busy),
        .load_done_o (a_done), .load_ovf_o (a_ovf)
    );

    inst_rom_loader #(
        .ADDR_WIDTH (c_AW), .DATA_WIDTH (c_DW), .DEPTH (c_DEPTH),
        .LOAD_BASE ((c_DEPTH-1)*4)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .fetch_req_i (fetch_req), .fetch_addr_i (fetch_addr),
        .fetch_gnt_o (b_gnt), .fetch_rvalid_o (b_rvalid),
        .fetch_rdata_o (b_rdata), .fetch_err_o (b_err),
        .load_start_i (load_start), .load_len_i (load_len),
        .load_valid_i (load_valid), .load_byte_i (load_byte),
        .load_ready_o (b_ready), .load_busy_o (b_busy),
        .load_done_o (b_done), .load_ovf_o (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses of instance A, sampled mid-cycle
    initial done_cnt = 0;
    always @(negedge clk) if (a_done === 1'b1) done_cnt = done_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a load of len bytes taken from stim[]; returns in the DONE cycle
    task automatic load_seq(input int len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < len; k++) begin
            load_valid = 1'b1;
            load_byte  = stim[k];
            tick();
        end
        load_valid = 1'b0;
    endtask

    // Request a fetch, wait (bounded) for the grant, return in the response cycle
    task automatic fetch(input logic [c_AW-1:0] addr);
        int n;
        n          = 0;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        while (a_gnt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (a_gnt !== 1'b1) begin
            $display("FAIL fetch_gnt_timeout addr=%h got=%b want=1", addr, a_gnt);
            failures++;
        end
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_byte = '0;
        #12;
        checks++; if (a_rvalid !== 1'b0) begin $display("FAIL reset_rvalid got=%b want=0", a_rvalid); failures++; end
        checks++; if (a_err !== 1'b0) begin $display("FAIL reset_err got=%b want=0", a_err); failures++; end
        checks++; if (a_rdata !== 32'h0) begin $display("FAIL reset_rdata got=%h want=0", a_rdata); failures++; end
        checks++; if ({a_ready, a_busy, a_done, a_ovf} !== 4'b0000) begin
            $display("FAIL reset_loader_flags got=%b want=0000", {a_ready, a_busy, a_done, a_ovf}); failures++; end
        rst_n = 1'b1;
        tick();
        checks++; if (a_gnt !== 1'b0) begin $display("FAIL reset_gnt_idle got=%b want=0", a_gnt); failures++; end
    endtask

    task automatic test_basic_load();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) stim[k] = 8'(k + 1);
        load_seq(8);
        checks++; if (a_done !== 1'b1) begin $display("FAIL basic_done got=%b want=1", a_done); failures++; end
        checks++; if (a_ovf !== 1'b0) begin $display("FAIL basic_ovf got=%b want=0", a_ovf); failures++; end
        checks++; if (a_busy !== 1'b1) begin $display("FAIL basic_busy_done got=%b want=1", a_busy); failures++; end
        tick();
        checks++; if ({a_done, a_busy} !== 2'b00) begin $display("FAIL basic_after_done got=%b want=00", {a_done, a_busy}); failures++; end
        checks++; if (done_cnt - d0 !== 1) begin $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); failures++; end
        fetch(32'd0);
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b10, 32'h04030201}) begin
            $display("FAIL basic_word0 got=%b/%b/%h want=1/0/04030201", a_rvalid, a_err, a_rdata); failures++; end
        fetch(32'd4);
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b10, 32'h08070605}) begin
            $display("FAIL basic_word1 got=%b/%b/%h want=1/0/08070605", a_rvalid, a_err, a_rdata); failures++; end
    endtask

    task automatic test_partial_word();
        stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'hEF; stim[5] = 8'hBE; stim[6] = 8'hAD; stim[7] = 8'hDE;
        load_seq(8);
        tick();
        fetch(32'd4);
        checks++; if (a_rdata !== 32'hDEADBEEF) begin $display("FAIL partial_preload got=%h want=DEADBEEF", a_rdata); failures++; end
        for (int k = 0; k < 6; k++) stim[k] = 8'(8'h11 + k);
        load_seq(6);
        tick();
        fetch(32'd0);
        checks++; if (a_rdata !== 32'h14131211) begin $display("FAIL partial_word0 got=%h want=14131211", a_rdata); failures++; end
        fetch(32'd4);
        checks++; if (a_rdata !== 32'hDEAD1615) begin $display("FAIL partial_word1 got=%h want=DEAD1615", a_rdata); failures++; end
    endtask

    task automatic test_fetch_err();
        fetch(32'd2);
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b11, 32'h0}) begin
            $display("FAIL err_misaligned got=%b/%b/%h want=1/1/0", a_rvalid, a_err, a_rdata); failures++; end
        fetch(32'(c_DEPTH * 4));
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b11, 32'h0}) begin
            $display("FAIL err_out_of_range got=%b/%b/%h want=1/1/0", a_rvalid, a_err, a_rdata); failures++; end
        fetch(32'd4);
        tick();
        checks++; if ({a_rvalid, a_rdata} !== {1'b0, 32'hDEAD1615}) begin
            $display("FAIL hold_rdata got=%b/%h want=0/DEAD1615", a_rvalid, a_rdata); failures++; end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) stim[k] = 8'(8'hA0 + k);
        load_seq(12);
        tick();
        fetch_req = 1'b1; fetch_addr = 32'd0;
        #1;
        checks++; if (a_gnt !== 1'b1) begin $display("FAIL b2b_gnt got=%b want=1", a_gnt); failures++; end
        tick();
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'hA3A2A1A0}) begin
            $display("FAIL b2b_first got=%b/%h want=1/A3A2A1A0", a_rvalid, a_rdata); failures++; end
        fetch_addr = 32'd4;
        tick();
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'hA7A6A5A4}) begin
            $display("FAIL b2b_second got=%b/%h want=1/A7A6A5A4", a_rvalid, a_rdata); failures++; end
        fetch_addr = 32'd8;
        tick();
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'hABAAA9A8}) begin
            $display("FAIL b2b_third got=%b/%h want=1/ABAAA9A8", a_rvalid, a_rdata); failures++; end
        fetch_req = 1'b0;
        tick();
        checks++; if (a_rvalid !== 1'b0) begin $display("FAIL b2b_idle got=%b want=0", a_rvalid); failures++; end
    endtask

    task automatic test_collision();
        fetch_req = 1'b1; fetch_addr = 32'd0;
        load_start = 1'b1; load_len = 32'd4;
        #1;
        checks++; if (a_gnt !== 1'b0) begin $display("FAIL coll_gnt got=%b want=0", a_gnt); failures++; end
        tick();
        load_start = 1'b0;
        checks++; if ({a_gnt, a_ready} !== 2'b01) begin $display("FAIL coll_in_load got=%b want=01", {a_gnt, a_ready}); failures++; end
        load_valid = 1'b1; load_byte = 8'h31;
        tick();
        load_byte = 8'h32; load_start = 1'b1; load_len = 32'd2;
        tick();
        load_start = 1'b0;
        checks++; if ({a_ready, a_done} !== 2'b10) begin $display("FAIL coll_restart_ignored got=%b want=10", {a_ready, a_done}); failures++; end
        load_byte = 8'h33;
        tick();
        load_byte = 8'h34;
        tick();
        load_valid = 1'b0;
        checks++; if ({a_done, a_gnt} !== 2'b10) begin $display("FAIL coll_done got=%b want=10", {a_done, a_gnt}); failures++; end
        tick();
        checks++; if ({a_gnt, a_rvalid} !== 2'b10) begin $display("FAIL coll_gnt_after_done got=%b want=10", {a_gnt, a_rvalid}); failures++; end
        tick();
        fetch_req = 1'b0;
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h34333231}) begin
            $display("FAIL coll_fetch got=%b/%h want=1/34333231", a_rvalid, a_rdata); failures++; end
        tick();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) stim[k] = 8'(8'h51 + k);
        load_seq(8);
        checks++; if ({b_done, b_ovf} !== 2'b11) begin $display("FAIL ovf_flag got=%b want=11", {b_done, b_ovf}); failures++; end
        checks++; if (a_ovf !== 1'b0) begin $display("FAIL ovf_inrange got=%b want=0", a_ovf); failures++; end
        tick();
        checks++; if (b_ovf !== 1'b0) begin $display("FAIL ovf_outside_done got=%b want=0", b_ovf); failures++; end
        fetch(32'((c_DEPTH - 1) * 4));
        checks++; if ({b_err, b_rdata} !== {1'b0, 32'h54535251}) begin
            $display("FAIL ovf_last_word got=%b/%h want=0/54535251", b_err, b_rdata); failures++; end
        load_start = 1'b1; load_len = 32'd0;
        tick();
        load_start = 1'b0;
        checks++; if ({b_done, b_busy, b_ovf} !== 3'b110) begin
            $display("FAIL zero_len_done got=%b want=110", {b_done, b_busy, b_ovf}); failures++; end
        tick();
        checks++; if (b_done !== 1'b0) begin $display("FAIL zero_len_single got=%b want=0", b_done); failures++; end
    endtask

    task automatic test_reset_midload();
        int d0;
        d0 = done_cnt;
        load_start = 1'b1; load_len = 32'd8;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_byte  = 8'(8'h61 + k);
            tick();
        end
        load_byte = 8'h64;
        rst_n = 1'b0;
        #1;
        checks++; if ({a_ready, a_busy, a_done, a_ovf} !== 4'b0000) begin
            $display("FAIL midload_flags got=%b want=0000", {a_ready, a_busy, a_done, a_ovf}); failures++; end
        checks++; if ({a_rvalid, a_err, a_rdata} !== {2'b00, 32'h0}) begin
            $display("FAIL midload_fetch_outs got=%b/%b/%h want=0/0/0", a_rvalid, a_err, a_rdata); failures++; end
        load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (done_cnt - d0 !== 0) begin $display("FAIL midload_no_done got=%0d want=0", done_cnt - d0); failures++; end
        fetch(32'd0);
        checks++; if (a_rdata !== 32'h54636261) begin $display("FAIL midload_readback got=%h want=54636261", a_rdata); failures++; end
        // Reset during an outstanding response drops it
        fetch_req = 1'b1; fetch_addr = 32'd4;
        tick();
        fetch_req = 1'b0;
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h58575655}) begin
            $display("FAIL pre_reset_resp got=%b/%h want=1/58575655", a_rvalid, a_rdata); failures++; end
        rst_n = 1'b0;
        #1;
        checks++; if (a_rvalid !== 1'b0) begin $display("FAIL reset_drops_resp got=%b want=0", a_rvalid); failures++; end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_load();
        test_partial_word();
        test_fetch_err();
        test_back_to_back();
        test_collision();
        test_overflow();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
